// File: rtl/effect_chain_pkg.sv
// Shared types and helpers for the effect_chain audio block: FSM states,
// mix/feedback scaling constants and a signed saturation helper.
package effect_chain_pkg;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_CRUSH,
        S_MIX,
        S_WRITE,
        S_DONE
    } state_e;

    // Mix and feedback amounts are fractions of this scale
    localparam int unsigned SCALE       = 256;
    localparam int unsigned SCALE_SHIFT = 8;

    // Widest operand the saturation helper accepts
    localparam int unsigned SAT_MAX_W = 96;

    // Clamp a wide signed value to the range of a dw-bit signed number
    function automatic logic signed [SAT_MAX_W-1:0] saturate(
        input logic signed [SAT_MAX_W-1:0] x,
        input int unsigned                 dw
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = $signed({SAT_MAX_W{1'b1}} >> (SAT_MAX_W - dw + 1));
        lo = ~hi;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/effect_delay_ram.sv
// Simple dual-port delay line storage: one write port, one read port with a
// registered (one-cycle) read.
module effect_delay_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32768,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/effect_chain.sv
// Per-frame bitcrush + feedback delay effect, processed one channel at a time.
// Define EFFECT_CHAIN_SAT_EN to saturate write/output values instead of wrapping.
module effect_chain
    import effect_chain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DELAY_DEPTH = 16384,
    localparam int unsigned AW         = $clog2(DELAY_DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] audio_in,
    output logic                         ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] audio_out,
    output logic                         audio_out_valid,
    input  logic                         enable_bitcrush,
    input  logic                         enable_delay,
    input  logic [4:0]                   bit_depth,
    input  logic [AW-1:0]                delay_samples,
    input  logic [7:0]                   feedback_amount,
    input  logic [7:0]                   mix
);

    localparam int unsigned CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned RAW       = CW + AW;
    localparam int unsigned RAM_DEPTH = NUM_CH * DELAY_DEPTH;
    localparam int unsigned PW        = DATA_WIDTH + 10;
    localparam int unsigned FW        = NUM_CH * DATA_WIDTH;

    state_e                        state_q, state_d;
    logic [CW-1:0]                 ch_q, ch_d;
    logic [RAW-1:0]                clr_q, clr_d;
    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]                 in_q, in_d;
    logic                          crush_en_q, crush_en_d;
    logic                          dly_en_q, dly_en_d;
    logic [4:0]                    bd_q, bd_d;
    logic [AW-1:0]                 dly_q, dly_d;
    logic [7:0]                    fb_q, fb_d;
    logic [7:0]                    mix_q, mix_d;
    logic signed [DATA_WIDTH-1:0]  crushed_q, crushed_d;
    logic [DATA_WIDTH-1:0]         wval_q, wval_d;
    logic [FW-1:0]                 obuf_q, obuf_d;
    logic [FW-1:0]                 audio_out_q, audio_out_d;
    logic                          valid_q, valid_d;
    logic                          ready_q, ready_d;

    logic                          ram_we_c;
    logic [RAW-1:0]                ram_waddr_c;
    logic [DATA_WIDTH-1:0]         ram_wdata_c;
    logic [RAW-1:0]                ram_raddr_c;
    logic [DATA_WIDTH-1:0]         ram_rdata;

    logic [DATA_WIDTH-1:0]         sample_c;
    logic [DATA_WIDTH-1:0]         mask_c;
    logic [DATA_WIDTH-1:0]         crush_c;
    logic signed [DATA_WIDTH-1:0]  delayed_c;
    logic signed [PW-1:0]          c_w, d_w, fb_w, mix_w, inv_w;
    logic signed [PW-1:0]          wsum_c, osum_c;

    function automatic logic signed [DATA_WIDTH-1:0] fit(input logic signed [PW-1:0] x);
`ifdef EFFECT_CHAIN_SAT_EN
        return DATA_WIDTH'(saturate(SAT_MAX_W'(x), DATA_WIDTH));
`else
        return DATA_WIDTH'(x);
`endif
    endfunction

    effect_delay_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (RAM_DEPTH),
        .ADDR_W    (RAW)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we_c),
        .waddr_i(ram_waddr_c),
        .wdata_i(ram_wdata_c),
        .raddr_i(ram_raddr_c),
        .rdata_o(ram_rdata)
    );

    // Bitcrush: keep the top bit_depth bits of the current channel's sample
    always_comb begin
        sample_c = in_q[32'(ch_q)*DATA_WIDTH +: DATA_WIDTH];
        mask_c   = {DATA_WIDTH{1'b1}} << (DATA_WIDTH - 32'(bd_q));
        if (crush_en_q && (bd_q != '0) && (32'(bd_q) < DATA_WIDTH)) begin
            crush_c = sample_c & mask_c;
        end else begin
            crush_c = sample_c;
        end
    end

    // Delay mix and feedback arithmetic at PW bits
    always_comb begin
        delayed_c = (dly_q == '0) ? crushed_q : $signed(ram_rdata);
        c_w       = PW'(crushed_q);
        d_w       = PW'(delayed_c);
        fb_w      = PW'(fb_q);
        mix_w     = PW'(mix_q);
        inv_w     = PW'(SCALE - 32'(mix_q));
        if (dly_en_q) begin
            wsum_c = c_w + ((d_w * fb_w) >>> SCALE_SHIFT);
            osum_c = ((c_w * inv_w) + (d_w * mix_w)) >>> SCALE_SHIFT;
        end else begin
            wsum_c = c_w;
            osum_c = c_w;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        clr_d       = clr_q;
        wr_ptr_d    = wr_ptr_q;
        in_d        = in_q;
        crush_en_d  = crush_en_q;
        dly_en_d    = dly_en_q;
        bd_d        = bd_q;
        dly_d       = dly_q;
        fb_d        = fb_q;
        mix_d       = mix_q;
        crushed_d   = crushed_q;
        wval_d      = wval_q;
        obuf_d      = obuf_q;
        audio_out_d = audio_out_q;
        valid_d     = 1'b0;
        ram_we_c    = 1'b0;
        ram_waddr_c = '0;
        ram_wdata_c = '0;
        ram_raddr_c = {ch_q, AW'(wr_ptr_q - dly_q)};

        case (state_q)
            S_CLEAR: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = clr_q;
                clr_d       = clr_q + RAW'(1);
                if (clr_q == RAW'(RAM_DEPTH - 1)) begin
                    clr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (sample_valid && ready_q) begin
                    in_d       = audio_in;
                    crush_en_d = enable_bitcrush;
                    dly_en_d   = enable_delay;
                    bd_d       = bit_depth;
                    dly_d      = delay_samples;
                    fb_d       = feedback_amount;
                    mix_d      = mix;
                    ch_d       = '0;
                    state_d    = S_CRUSH;
                end
            end
            S_CRUSH: begin
                crushed_d = crush_c;
                state_d   = S_MIX;
            end
            S_MIX: begin
                wval_d = fit(wsum_c);
                obuf_d[32'(ch_q)*DATA_WIDTH +: DATA_WIDTH] = fit(osum_c);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = {ch_q, wr_ptr_q};
                ram_wdata_c = wval_q;
                if (ch_q == CW'(NUM_CH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = S_CRUSH;
                end
            end
            S_DONE: begin
                audio_out_d = obuf_q;
                valid_d     = 1'b1;
                wr_ptr_d    = wr_ptr_q + AW'(1);
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q        <= '0;
            clr_q       <= '0;
            wr_ptr_q    <= '0;
            in_q        <= '0;
            crush_en_q  <= 1'b0;
            dly_en_q    <= 1'b0;
            bd_q        <= '0;
            dly_q       <= '0;
            fb_q        <= '0;
            mix_q       <= '0;
            crushed_q   <= '0;
            wval_q      <= '0;
            obuf_q      <= '0;
            audio_out_q <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            clr_q       <= clr_d;
            wr_ptr_q    <= wr_ptr_d;
            in_q        <= in_d;
            crush_en_q  <= crush_en_d;
            dly_en_q    <= dly_en_d;
            bd_q        <= bd_d;
            dly_q       <= dly_d;
            fb_q        <= fb_d;
            mix_q       <= mix_d;
            crushed_q   <= crushed_d;
            wval_q      <= wval_d;
            obuf_q      <= obuf_d;
            audio_out_q <= audio_out_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
        end
    end

    assign ready           = ready_q;
    assign audio_out       = audio_out_q;
    assign audio_out_valid = valid_q;

endmodule

// File: tb/tb_effect_chain.sv
// Self-checking bench for effect_chain (DATA_WIDTH=32, NUM_CH=2, DELAY_DEPTH=16).
// Honours EFFECT_CHAIN_SAT_EN in its reference model.
module tb_effect_chain;

    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [63:0] audio_in = '0;
    logic        ready;
    logic [63:0] audio_out;
    logic        audio_out_valid;
    logic        enable_bitcrush = 1'b0;
    logic        enable_delay = 1'b0;
    logic [4:0]  bit_depth = '0;
    logic [3:0]  delay_samples = '0;
    logic [7:0]  feedback_amount = '0;
    logic [7:0]  mix = '0;

    always #5 clk = ~clk;

    effect_chain #(
        .DATA_WIDTH (32),
        .NUM_CH     (2),
        .DELAY_DEPTH(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .audio_in       (audio_in),
        .ready          (ready),
        .audio_out      (audio_out),
        .audio_out_valid(audio_out_valid),
        .enable_bitcrush(enable_bitcrush),
        .enable_delay   (enable_delay),
        .bit_depth      (bit_depth),
        .delay_samples  (delay_samples),
        .feedback_amount(feedback_amount),
        .mix            (mix)
    );

    typedef struct {
        int in0;
        int in1;
        bit bc;
        bit dl;
        int bd;
        int ds;
        int fb;
        int mx;
    } frame_t;

    typedef struct {
        frame_t f;
        int     exp0;
        int     exp1;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int m_mem [2][16];
    int m_wp;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, got, got[31:0], exp, exp[31:0]);
        end
    endtask

    // Reference model: behaviour of one frame in plain integer arithmetic
    function automatic int fit_m(input longint x);
`ifdef EFFECT_CHAIN_SAT_EN
        if (x > LMAX) return int'(LMAX);
        if (x < LMIN) return int'(LMIN);
        return int'(x);
`else
        return int'(x);
`endif
    endfunction

    function automatic longint crush_m(input longint x, input bit en, input int bd);
        int sh;
        if (en && bd >= 1 && bd < 32) begin
            sh = 32 - bd;
            return (x >>> sh) <<< sh;
        end
        return x;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++) m_mem[c][a] = 0;
        m_wp = 0;
    endtask

    task automatic model_frame(input frame_t f, output int e0, output int e1);
        int     ins [2];
        int     ex  [2];
        longint c, d, w, o;
        ins[0] = f.in0;
        ins[1] = f.in1;
        for (int ch = 0; ch < 2; ch++) begin
            c = crush_m(longint'(ins[ch]), f.bc, f.bd);
            if (f.ds == 0) d = c;
            else d = longint'(m_mem[ch][(m_wp - f.ds + 16) % 16]);
            if (f.dl) begin
                w = c + ((d * longint'(f.fb)) >>> 8);
                o = (c * longint'(256 - f.mx) + d * longint'(f.mx)) >>> 8;
            end else begin
                w = c;
                o = c;
            end
            m_mem[ch][m_wp] = fit_m(w);
            ex[ch] = fit_m(o);
        end
        m_wp = (m_wp + 1) % 16;
        e0 = ex[0];
        e1 = ex[1];
    endtask

    task automatic scramble();
        audio_in        = {$urandom, $urandom};
        enable_bitcrush = 1'($urandom_range(0, 1));
        enable_delay    = 1'($urandom_range(0, 1));
        bit_depth       = 5'($urandom_range(0, 31));
        delay_samples   = 4'($urandom_range(0, 15));
        feedback_amount = 8'($urandom_range(0, 255));
        mix             = 8'($urandom_range(0, 255));
    endtask

    task automatic run_frame(input frame_t f, input bit poke, output int g0, output int g1);
        int lat;
        bit extra;
        lat = 0;
        extra = 1'b0;
        @(negedge clk);
        chk("ready_before_frame", longint'(ready), 1);
        audio_in        = {f.in1, f.in0};
        enable_bitcrush = f.bc;
        enable_delay    = f.dl;
        bit_depth       = 5'(f.bd);
        delay_samples   = 4'(f.ds);
        feedback_amount = 8'(f.fb);
        mix             = 8'(f.mx);
        sample_valid    = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        scramble();
        for (int k = 1; k <= 30; k++) begin
            if (poke && k == 3) sample_valid = 1'b1;
            if (poke && k == 4) sample_valid = 1'b0;
            @(posedge clk);
            #1;
            if (audio_out_valid) begin
                lat = k;
                break;
            end
        end
        chk("valid_latency", longint'(lat), 7);
        g0 = int'(audio_out[31:0]);
        g1 = int'(audio_out[63:32]);
        @(posedge clk);
        #1;
        chk("valid_single_pulse", longint'(audio_out_valid), 0);
        if (poke) begin
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                if (audio_out_valid) extra = 1'b1;
            end
            chk("busy_strobe_ignored", longint'(extra), 0);
        end
    endtask

    task automatic do_reset();
        int lat;
        lat = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_audio_out", longint'(audio_out), 0);
        chk("reset_valid", longint'(audio_out_valid), 0);
        chk("reset_ready", longint'(ready), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = k;
                break;
            end
        end
        chk("ready_after_reset_cycles", longint'(lat), 32);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs [7];
        frame_t f;
        int     g0, g1, e0, e1;
        int     echo_exp [6];
        bit     seen;

        // Bitcrush / passthrough vectors (delay off, so memory history is irrelevant)
        vecs[0] = '{'{-5, 7, 1'b0, 1'b0, 0, 0, 0, 0}, -5, 7};
        vecs[1] = '{'{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4, 0, 0, 0}, 32'h7000_0000, 32'hF000_0000};
        vecs[2] = '{'{32'h7FFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 0, 5, 9, 77}, 32'h7FFF_FFFF, 32'h1234_5678};
        vecs[3] = '{'{32'h7FFF_FFFF, 32'h8000_0001, 1'b1, 1'b0, 31, 0, 0, 0}, 32'h7FFF_FFFE, 32'h8000_0000};
        vecs[4] = '{'{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1, 0, 0, 0}, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{'{32'h7FFF_FFFF, -123, 1'b0, 1'b0, 4, 0, 0, 0}, 32'h7FFF_FFFF, -123};
        vecs[6] = '{'{32'h1234_ABCD, 32'hFFFF_8001, 1'b1, 1'b0, 16, 2, 0, 0}, 32'h1234_0000, 32'hFFFF_0000};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].f, 1'b0, g0, g1);
            model_frame(vecs[i].f, e0, e1);
            chk($sformatf("vec%0d_ch0", i), longint'(g0), longint'(vecs[i].exp0));
            chk($sformatf("vec%0d_ch1", i), longint'(g1), longint'(vecs[i].exp1));
        end

        // Impulse through a 3-sample delay, fully wet, no feedback
        do_reset();
        echo_exp = '{3, 0, 0, 996, 0, 0};
        for (int i = 0; i < 6; i++) begin
            f = '{(i == 0) ? 1000 : 0, 0, 1'b0, 1'b1, 0, 3, 0, 255};
            run_frame(f, 1'b0, g0, g1);
            model_frame(f, e0, e1);
            chk($sformatf("echo3_f%0d_ch0", i), longint'(g0), longint'(echo_exp[i]));
            chk($sformatf("echo3_f%0d_ch1", i), longint'(g1), 0);
        end

        // 15-sample delay across a pointer wrap, with strobes while busy
        do_reset();
        for (int i = 0; i < 20; i++) begin
            f = '{(i == 0) ? 1000 : 0, 0, 1'b0, 1'b1, 0, 15, 0, 255};
            run_frame(f, (i == 2 || i == 17), g0, g1);
            model_frame(f, e0, e1);
            chk($sformatf("echo15_f%0d_ch0", i), longint'(g0),
                (i == 0) ? 64'sd3 : ((i == 15) ? 64'sd996 : 64'sd0));
            chk($sformatf("echo15_f%0d_ch1", i), longint'(g1), 0);
        end

        // Random frames against the reference model
        for (int i = 0; i < 40; i++) begin
            f.in0 = int'($urandom);
            f.in1 = int'($urandom);
            f.bc  = 1'($urandom_range(0, 1));
            f.dl  = 1'($urandom_range(0, 3) != 0);
            f.bd  = int'($urandom_range(0, 31));
            f.ds  = int'($urandom_range(0, 15));
            f.fb  = int'($urandom_range(0, 255));
            f.mx  = int'($urandom_range(0, 255));
            run_frame(f, 1'b0, g0, g1);
            model_frame(f, e0, e1);
            chk($sformatf("rand%0d_ch0", i), longint'(g0), longint'(e0));
            chk($sformatf("rand%0d_ch1", i), longint'(g1), longint'(e1));
        end

        // Overflowing feedback: clamps with saturation, wraps without
        do_reset();
        for (int i = 0; i < 4; i++) begin
            f = '{32'h7000_0000, 32'h9000_0000, 1'b0, 1'b1, 0, 1, 255, 128};
            run_frame(f, 1'b0, g0, g1);
            model_frame(f, e0, e1);
            chk($sformatf("ovf%0d_ch0", i), longint'(g0), longint'(e0));
            chk($sformatf("ovf%0d_ch1", i), longint'(g1), longint'(e1));
            if (i == 2) begin
`ifdef EFFECT_CHAIN_SAT_EN
                chk("ovf2_ch0_const", longint'(g0), 64'sh77FF_FFFF);
`else
                chk("ovf2_ch0_const", longint'(g0), 64'sh27C8_0000);
`endif
            end
        end

        // Reset while the first channel is in MIX: frame discarded, CLEAR restarts
        @(negedge clk);
        audio_in     = {32'd7, -32'sd5};
        enable_delay = 1'b0;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_out_zero", longint'(audio_out), 0);
        chk("abort_valid_low", longint'(audio_out_valid), 0);
        chk("abort_ready_low", longint'(ready), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        g0 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (audio_out_valid) seen = 1'b1;
            if (ready) begin
                g0 = k;
                break;
            end
        end
        chk("abort_no_valid", longint'(seen), 0);
        chk("abort_ready_cycles", longint'(g0), 32);

        f = '{-5, 7, 1'b0, 1'b0, 0, 0, 0, 0};
        run_frame(f, 1'b0, g0, g1);
        model_frame(f, e0, e1);
        chk("post_abort_ch0", longint'(g0), -5);
        chk("post_abort_ch1", longint'(g1), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/effect_chain.md
EFFECT_CHAIN -- requirements
Module: effect_chain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed sample width per channel.
REQ-002 SHALL have parameter NUM_CH, default 2, channels per frame, range 1..8.
REQ-003 SHALL have parameter DELAY_DEPTH, default 16384, delay samples per channel, power of two; AW = clog2(DELAY_DEPTH).
REQ-004 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sample_valid  input  1  one-cycle frame strobe, accepted only while ready=1.
REQ-007 SHALL have port audio_in  input  NUM_CH*DATA_WIDTH  signed frame; channel 0 in LSBs.
REQ-008 SHALL have port ready  output  1  high only in IDLE.
REQ-009 SHALL have port audio_out  output  NUM_CH*DATA_WIDTH  processed frame, held until next frame completes.
REQ-010 SHALL have port audio_out_valid  output  1  one-cycle pulse per completed frame.
REQ-011 SHALL have ports enable_bitcrush, enable_delay  input  1 each  effect enables.
REQ-012 SHALL have ports bit_depth  input  5; delay_samples  input  AW; feedback_amount  input  8; mix  input  8 (wet fraction, /256).

Function
REQ-013 SHALL latch audio_in and all control inputs on sample_valid&&ready; changes mid-frame have no effect until the next frame.
REQ-014 SHALL implement FSM CLEAR -> IDLE -> {CRUSH -> MIX -> WRITE} per channel 0..NUM_CH-1 -> DONE -> IDLE.
REQ-015 SHALL spend exactly one cycle in each of CRUSH, MIX, WRITE, DONE; audio_out_valid pulses in DONE, 3*NUM_CH+1 cycles after the accepting edge.
REQ-016 SHALL ignore sample_valid while ready=0 (no queueing, no error flag).
REQ-017 Bitcrush: enable_bitcrush=1 and 1<=bit_depth<DATA_WIDTH keeps top bit_depth bits, zeroes the rest; bit_depth=0 or enable_bitcrush=0 passes the sample unchanged.
REQ-018 Delay read address SHALL be {ch, wr_ptr - delay_samples} modulo DELAY_DEPTH; delay_samples=0 makes delayed = crushed sample.
REQ-019 enable_delay=1: write value = crushed + ((delayed*feedback_amount)>>>8); out = (crushed*(256-mix) + delayed*mix)>>>8.
REQ-020 enable_delay=0: write value = crushed (no feedback); out = crushed.
REQ-021 wr_ptr SHALL increment once per frame in DONE, wrapping DELAY_DEPTH-1 -> 0.
REQ-022 Intermediate products SHALL use DATA_WIDTH+10 bits; arithmetic shifts preserve sign.

Reset
REQ-023 On reset: audio_out=0, audio_out_valid=0, ready=0, wr_ptr=0, FSM -> CLEAR, regardless of current state (mid-frame abort; partial frame discarded, no valid pulse).
REQ-024 CLEAR SHALL write zero to all NUM_CH*DELAY_DEPTH locations, one per cycle, then enter IDLE; ready rises exactly NUM_CH*DELAY_DEPTH cycles after reset deassertion.

Configuration
REQ-025 With EFFECT_CHAIN_SAT_EN defined, write value and out SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 Without EFFECT_CHAIN_SAT_EN, both SHALL be truncated to DATA_WIDTH bits (two's-complement wrap).

Structure
REQ-027 Package effect_chain_pkg SHALL hold the FSM state enum, the saturate function, and the mix/feedback scale constant 256.
REQ-028 Delay storage SHALL be sub-module effect_delay_ram: simple dual-port, depth NUM_CH*DELAY_DEPTH, width DATA_WIDTH, one-cycle registered read.

Verification (DATA_WIDTH=32, NUM_CH=2, DELAY_DEPTH=16)
REQ-029 Reset release -> ready rises after 32 cycles; first frame with all enables 0, audio_in={-5,7} -> audio_out={-5,7}, valid 7 cycles after accept.
REQ-030 enable_bitcrush=1, bit_depth=4, input 0x7FFF_FFFF -> output 0x7000_0000; bit_depth=0 -> 0x7FFF_FFFF.
REQ-031 enable_delay=1, mix=255, feedback=0, delay_samples=3, impulse 1000 on ch0 then zeros -> ch0 out 996 on frame 4 only, ch1 0 throughout.
REQ-032 delay_samples=15, 20 frames -> wr_ptr wraps 15->0, echo of frame 0 appears on frame 15; sample_valid during busy -> ignored, no extra valid pulse.
REQ-033 SAT_EN on, in 0x7000_0000, feedback=255, mix=128, delay=1 -> written/output values clamp at 0x7FFF_FFFF; reset asserted mid-MIX -> no valid pulse, CLEAR restarts.
